// File: rtl/sound_ready_gen.sv
// Sound-port write stretcher: latches the CPU byte, strobes the sound chip and holds
// SOUND_READY low for WAIT_CYCLES CPU clocks. Optional write counter: SOUND_WRITE_COUNT_EN.
module sound_ready_gen #(
   parameter int WAIT_CYCLES = 32,
   parameter int COUNT_WIDTH = 6
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       cpu_clock_posedge,
   input  logic       cpu_clock_negedge,
   input  logic       sound_cs_n,
   input  logic       io_write_n,
   input  logic [7:0] data_in,
   output logic       SOUND_READY,
   output logic [7:0] sound_data,
`ifdef SOUND_WRITE_COUNT_EN
   output logic [15:0] write_count,
`endif
   output logic       sound_we_n
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   localparam logic [COUNT_WIDTH-1:0] CNT_LOAD = COUNT_WIDTH'(WAIT_CYCLES - 1);

   logic [1:0]             r_state;
   logic [COUNT_WIDTH-1:0] r_cnt;
   logic                   r_ready;
   logic                   r_we_n;
   logic [7:0]             r_data;

   logic w_req;
   logic w_wait_done;
   logic w_unused_negedge;

   assign w_req            = ~sound_cs_n & ~io_write_n;
   assign w_wait_done      = cpu_clock_posedge && (r_state == S_WAIT) && (r_cnt == '0);
   // The CPU falling-edge strobe is part of the bus contract but plays no role in this FSM.
   assign w_unused_negedge = cpu_clock_negedge;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ready <= 1'b1;
         r_we_n  <= 1'b1;
         r_data  <= 8'h00;
      end else if (cpu_clock_posedge) begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_state <= S_WAIT;
                  r_ready <= 1'b0;
                  r_we_n  <= 1'b0;
                  r_data  <= data_in;
                  r_cnt   <= CNT_LOAD;
               end
            end
            S_WAIT: begin
               // A request dropped mid-wait still runs the full count out.
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - COUNT_WIDTH'(1);
               end else begin
                  r_state <= S_RELEASE;
                  r_ready <= 1'b1;
                  r_we_n  <= 1'b1;
               end
            end
            S_RELEASE: begin
               // Held write must be removed before another one can be accepted.
               if (!w_req) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef SOUND_WRITE_COUNT_EN
   logic [15:0] r_write_count;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_write_count <= 16'h0000;
      end else if (w_wait_done) begin
         r_write_count <= r_write_count + 16'h0001;
      end
   end

   assign write_count = r_write_count;
`endif

   assign SOUND_READY = r_ready;
   assign sound_we_n  = r_we_n;
   assign sound_data  = r_data;

endmodule
